wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters.
  - Requester A: the main pipeline writeback, normally high priority.
  - Requester B: the multi-cycle multiply/divide/load return path.
- Selects the 5-bit destination address and 32-bit data with fixed priority for A and a starvation guard for B.
- Drives registered write-port signals into the register file.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width.
- STARVE_LIMIT, 4, consecutive cycles B may wait before A is stalled in B's favour (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_valid  input  1  pipeline writeback request.
- a_addr  input  ADDR_W  pipeline destination register.
- a_data  input  DATA_W  pipeline write data.
- a_ready  output  1  pipeline request accepted this cycle; low means stall the pipeline.
- b_valid  input  1  multi-cycle unit writeback request.
- b_addr  input  ADDR_W  multi-cycle destination register.
- b_data  input  DATA_W  multi-cycle write data.
- b_ready  output  1  multi-cycle request accepted this cycle.
- rf_we  output  1  register-file write enable.
- rf_waddr  output  ADDR_W  register-file write address.
- rf_wdata  output  DATA_W  register-file write data.
- rf_wsrc  output  1  source of the current write: 0 = A, 1 = B.

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous, active-low.
- Reset values (asynchronous assertion):
  - rf_we=0, rf_waddr=0, rf_wdata=0, rf_wsrc=0.
  - state=PRI_A, wait_cnt=0.
- Reset is released synchronously to the design's clock; there is no internal synchronizer.
- Handshake:
  - Each requester holds valid, addr and data stable until it sees ready high.
  - Transfer happens on a clock edge where valid && ready.
  - a_ready and b_ready are combinational from valid inputs and state. They never depend on rf_* outputs.
- Latency: an accepted request appears on rf_* exactly one cycle after the handshake edge. rf_we is high for one cycle per transfer.
- FSM has two states, PRI_A and FORCE_B.
- State PRI_A:
  - a_ready = a_valid.
  - b_ready = b_valid && !a_valid.
  - When b_valid && a_valid, wait_cnt increments. When wait_cnt reaches STARVE_LIMIT-1 in such a cycle, next state is FORCE_B.
  - wait_cnt clears to 0 on any B transfer or when b_valid=0.
- State FORCE_B:
  - a_ready = 0.
  - b_ready = b_valid.
  - On a B transfer: return to PRI_A and clear wait_cnt.
  - If b_valid=0 (protocol violation): return to PRI_A with no transfer and clear wait_cnt.
- Register 0 filter:
  - A transfer with addr==0 completes its handshake normally.
  - The next cycle rf_we=0. rf_waddr, rf_wdata and rf_wsrc still update.
- Idle: when no transfer occurs, the next cycle rf_we=0. rf_waddr, rf_wdata and rf_wsrc hold their previous values.
- Same-address collision:
  - No merging. Writes occur in grant order, each as a separate rf_we cycle.
  - Ordering between A and B to the same register is the pipeline's responsibility (scoreboard upstream).
- Width rules: addresses and data pass through unmodified. wait_cnt is 4 bits and saturates at 15.
- Reset mid-operation:
  - All outputs return to reset values immediately.
  - A handshake in the same cycle as reset assertion is discarded.
  - State returns to PRI_A.

Test Plan:
- Reset: hold rst_n=0 with both valid -> rf_we=0, rf_waddr=0, rf_wdata=0, a_ready=0, b_ready=0; release -> first write one cycle after the first handshake.
- A alone: a_valid=1, a_addr=5'd8, a_data=32'h1234_5678 for 1 cycle -> a_ready=1 the same cycle; next cycle rf_we=1, rf_waddr=8, rf_wdata=32'h12345678, rf_wsrc=0.
- Contention, STARVE_LIMIT=4: A valid every cycle with addr 9..13, B valid addr=5'd31 data=32'hDEAD_BEEF -> A granted 4 cycles; 5th cycle a_ready=0, b_ready=1; next cycle rf_waddr=31, rf_wsrc=1; then A resumes with its held request.
- B alone: b_valid=1, addr=5'd2 -> b_ready=1 immediately, rf_we one cycle later, wait_cnt stays 0.
- Zero register: a_valid=1, a_addr=0, a_data=32'hFFFF_FFFF -> a_ready=1; next cycle rf_we=0.
- Reset mid-force: enter FORCE_B, assert rst_n=0 before b transfer -> rf_we=0 at once; after release a_valid alone -> a_ready=1 (state PRI_A, wait_cnt=0).

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: fixed priority for the pipeline (A) with a
// starvation guard that forces one grant to the multi-cycle return path (B).
module wb_port_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              rf_wsrc
);

   typedef enum logic {PRI_A = 1'b0, FORCE_B = 1'b1} state_t;

   localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

   state_t     state_reg, state_next;
   logic [3:0] wait_cnt_reg, wait_cnt_next;
   logic       a_go, b_go;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= PRI_A;
         wait_cnt_reg <= 4'd0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      a_ready       = 1'b0;
      b_ready       = 1'b0;
      unique case (state_reg)
         PRI_A: begin
            a_ready = a_valid;
            b_ready = b_valid && !a_valid;
            if (a_valid && b_valid) begin
               if (wait_cnt_reg != 4'hF)
                  wait_cnt_next = wait_cnt_reg + 4'd1;
               if (wait_cnt_reg >= LIMIT_M1)
                  state_next = FORCE_B;
            end else begin
               // B either transfers this cycle or is not waiting at all
               wait_cnt_next = 4'd0;
            end
         end
         FORCE_B: begin
            b_ready       = b_valid;
            state_next    = PRI_A;
            wait_cnt_next = 4'd0;
         end
      endcase
      // no handshake may be offered while reset is held
      if (!rst_n) begin
         a_ready = 1'b0;
         b_ready = 1'b0;
      end
   end

   assign a_go = a_valid && a_ready;
   assign b_go = b_valid && b_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         rf_wsrc  <= 1'b0;
      end else begin
         rf_we <= 1'b0;
         // register 0 is hardwired: the transfer completes but never writes
         if (a_go) begin
            rf_we    <= (a_addr != '0);
            rf_waddr <= a_addr;
            rf_wdata <= a_data;
            rf_wsrc  <= 1'b0;
         end else if (b_go) begin
            rf_we    <= (b_addr != '0);
            rf_waddr <= b_addr;
            rf_wdata <= b_data;
            rf_wsrc  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a grant model queues expected writes,
// a negedge monitor checks ready signals and every rf_* cycle against the queue.
module tb_wb_port_arbiter;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int LIMIT = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          a_valid = 1'b0;
   logic [AW-1:0] a_addr = '0;
   logic [DW-1:0] a_data = '0;
   logic          b_valid = 1'b0;
   logic [AW-1:0] b_addr = '0;
   logic [DW-1:0] b_data = '0;
   logic          a_ready, b_ready, rf_we, rf_wsrc;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          src;
      int            due;
   } wr_t;

   wr_t           exp_q[$];
   int            n_tests = 0;
   int            n_fail = 0;
   int            cyc = 0;
   int            a_wins = 0;   // consecutive cycles A won while B was waiting
   logic          exp_a_ready = 1'b0;
   logic          exp_b_ready = 1'b0;
   logic [AW-1:0] last_addr = '0;
   logic [DW-1:0] last_data = '0;
   logic          last_src = 1'b0;
   bit            mon_en = 1'b0;
   bit            ga, gb;

   wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(LIMIT)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .a_valid  (a_valid),
      .a_addr   (a_addr),
      .a_data   (a_data),
      .a_ready  (a_ready),
      .b_valid  (b_valid),
      .b_addr   (b_addr),
      .b_data   (b_data),
      .b_ready  (b_ready),
      .rf_we    (rf_we),
      .rf_waddr (rf_waddr),
      .rf_wdata (rf_wdata),
      .rf_wsrc  (rf_wsrc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Grant rule: after LIMIT straight losses B must win next (or nobody, if B
   // dropped its request); otherwise A wins whenever it asks.
   task automatic tick(output bit g_a, output bit g_b);
      wr_t e;
      bit  forced;
      forced = (a_wins >= LIMIT);
      g_a = 1'b0;
      g_b = 1'b0;
      if (forced) begin
         g_b = b_valid;
      end else begin
         g_a = a_valid;
         g_b = b_valid && !a_valid;
      end
      exp_a_ready = g_a;
      exp_b_ready = g_b;
      if (g_a || g_b) begin
         e.src  = g_b;
         e.addr = g_b ? b_addr : a_addr;
         e.data = g_b ? b_data : a_data;
         e.we   = (e.addr != '0);
         e.due  = cyc + 1;
         exp_q.push_back(e);
      end
      if (!forced && g_a && b_valid) a_wins++;
      else a_wins = 0;
      @(posedge clk);
      #1;
      if (g_a) a_valid = 1'b0;
      if (g_b) b_valid = 1'b0;
   endtask

   always @(negedge clk) begin : monitor
      wr_t e;
      if (rst_n && mon_en) begin
         chk("a_ready", 64'(a_ready), 64'(exp_a_ready));
         chk("b_ready", 64'(b_ready), 64'(exp_b_ready));
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk("rf_we", 64'(rf_we), 64'(e.we));
            chk("rf_waddr", 64'(rf_waddr), 64'(e.addr));
            chk("rf_wdata", 64'(rf_wdata), 64'(e.data));
            chk("rf_wsrc", 64'(rf_wsrc), 64'(e.src));
            last_addr = e.addr;
            last_data = e.data;
            last_src  = e.src;
            $display("[TB] cycle %0d write src=%0d addr=%0d data=%08h we=%0d",
                     cyc, rf_wsrc, rf_waddr, rf_wdata, rf_we);
         end else begin
            chk("rf_we_idle", 64'(rf_we), 64'(0));
            chk("rf_waddr_hold", 64'(rf_waddr), 64'(last_addr));
            chk("rf_wdata_hold", 64'(rf_wdata), 64'(last_data));
            chk("rf_wsrc_hold", 64'(rf_wsrc), 64'(last_src));
         end
      end
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rf_we"}, 64'(rf_we), 64'(0));
      chk({tag, "_rf_waddr"}, 64'(rf_waddr), 64'(0));
      chk({tag, "_rf_wdata"}, 64'(rf_wdata), 64'(0));
      chk({tag, "_rf_wsrc"}, 64'(rf_wsrc), 64'(0));
      chk({tag, "_a_ready"}, 64'(a_ready), 64'(0));
      chk({tag, "_b_ready"}, 64'(b_ready), 64'(0));
   endtask

   initial begin
      // reset held with both requesters asking
      a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h0BAD_0001;
      b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h0BAD_0002;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      mon_en = 1'b1;
      tick(ga, gb);

      // A alone
      a_valid = 1'b1; a_addr = 5'd8; a_data = 32'h1234_5678;
      tick(ga, gb);
      tick(ga, gb);

      // contention: A streams 9.., B waits with 31/DEADBEEF
      a_valid = 1'b1; a_addr = 5'd9; a_data = 32'($urandom);
      b_valid = 1'b1; b_addr = 5'd31; b_data = 32'hDEAD_BEEF;
      for (int i = 0; i < 6; i++) begin
         tick(ga, gb);
         if (ga) begin
            a_valid = 1'b1;
            a_addr  = a_addr + 5'd1;
            a_data  = 32'($urandom);
         end
      end
      a_valid = 1'b0;
      tick(ga, gb);

      // B alone
      b_valid = 1'b1; b_addr = 5'd2; b_data = 32'hCAFE_0002;
      tick(ga, gb);
      tick(ga, gb);

      // zero register
      a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFF_FFFF;
      tick(ga, gb);
      tick(ga, gb);

      // drive into the forced state, then reset before B transfers
      b_valid = 1'b1; b_addr = 5'd17; b_data = 32'h5555_AAAA;
      for (int i = 0; i < LIMIT; i++) begin
         a_valid = 1'b1;
         a_addr  = 5'(i + 20);
         a_data  = 32'($urandom);
         tick(ga, gb);
      end
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      exp_q.delete();
      a_wins = 0;
      last_addr = '0;
      last_data = '0;
      last_src = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      b_valid = 1'b0;
      a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h7777_0007;
      tick(ga, gb);
      tick(ga, gb);

      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         if (!a_valid && $urandom_range(0, 99) < 60) begin
            a_valid = 1'b1;
            a_addr  = 5'($urandom_range(0, 31));
            a_data  = 32'($urandom);
         end
         if (!b_valid && $urandom_range(0, 99) < 40) begin
            b_valid = 1'b1;
            b_addr  = 5'($urandom_range(0, 31));
            b_data  = 32'($urandom);
         end
         tick(ga, gb);
      end

      a_valid = 1'b0;
      b_valid = 1'b0;
      // drain whatever request is still pending, then settle
      for (int i = 0; i < 3; i++) tick(ga, gb);
      chk("queue_drained", 64'(exp_q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
